// File: rtl/spi_ram_pkg.sv
// Shared command codes and FSM state encoding for the SPI-to-RAM command sequencer.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

endpackage

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI frames into address-latch, write and read operations on a
// single-port RAM and returns read data to the SPI serializer. All outputs registered.
module spi_ram_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int AUTO_INC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              busy,
    output logic              cmd_err
);
    import spi_ram_pkg::*;

    localparam logic [1:0]        LAT_M1 = 2'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    state_t            state_reg,     state_next;
    logic [ADDR_W-1:0] wr_addr_reg,   wr_addr_next;
    logic [ADDR_W-1:0] rd_addr_reg,   rd_addr_next;
    logic              rd_armed_reg,  rd_armed_next;
    logic [1:0]        cnt_reg,       cnt_next;
    logic [7:0]        tx_data_reg,   tx_data_next;
    logic              tx_valid_reg,  tx_valid_next;
    logic              ram_en_reg,    ram_en_next;
    logic              ram_we_reg,    ram_we_next;
    logic [ADDR_W-1:0] ram_addr_reg,  ram_addr_next;
    logic [7:0]        ram_wdata_reg, ram_wdata_next;
    logic              busy_reg,      busy_next;
    logic              cmd_err_reg,   cmd_err_next;

    // RAM strobes are computed on the transition into WRITE/READ so the
    // registered outputs line up with the cycle the FSM sits in that state.
    always_comb begin
        state_next     = state_reg;
        wr_addr_next   = wr_addr_reg;
        rd_addr_next   = rd_addr_reg;
        rd_armed_next  = rd_armed_reg;
        cnt_next       = cnt_reg;
        tx_data_next   = tx_data_reg;
        tx_valid_next  = 1'b0;
        ram_en_next    = 1'b0;
        ram_we_next    = 1'b0;
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = 8'h00;
        cmd_err_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data[9:8])
                        CMD_WR_ADDR: wr_addr_next = rx_data[ADDR_W-1:0];
                        CMD_WR_DATA: begin
                            state_next     = ST_WRITE;
                            ram_en_next    = 1'b1;
                            ram_we_next    = 1'b1;
                            ram_addr_next  = wr_addr_reg;
                            ram_wdata_next = rx_data[7:0];
                        end
                        CMD_RD_ADDR: begin
                            rd_addr_next  = rx_data[ADDR_W-1:0];
                            rd_armed_next = 1'b1;
                        end
                        CMD_RD_DATA: begin
                            if (rd_armed_reg) begin
                                state_next    = ST_READ;
                                ram_en_next   = 1'b1;
                                ram_addr_next = rd_addr_reg;
                            end else begin
                                cmd_err_next = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WRITE: begin
                if (AUTO_INC != 0) wr_addr_next = wr_addr_reg + ONE;
                state_next = ST_IDLE;
            end
            ST_READ: begin
                if (AUTO_INC != 0) rd_addr_next = rd_addr_reg + ONE;
                else               rd_armed_next = 1'b0;
                cnt_next   = LAT_M1;
                state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cnt_reg == 2'd0) begin
                    tx_data_next  = ram_rdata;
                    tx_valid_next = 1'b1;
                    state_next    = ST_SEND;
                end else begin
                    cnt_next = cnt_reg - 2'd1;
                end
            end
            ST_SEND: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // Frames arriving mid-operation are dropped without touching the in-flight op.
        if (rx_valid && (state_reg != ST_IDLE)) cmd_err_next = 1'b1;

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wr_addr_reg   <= '0;
            rd_addr_reg   <= '0;
            rd_armed_reg  <= 1'b0;
            cnt_reg       <= 2'd0;
            tx_data_reg   <= 8'h00;
            tx_valid_reg  <= 1'b0;
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= 8'h00;
            busy_reg      <= 1'b0;
            cmd_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_addr_reg   <= wr_addr_next;
            rd_addr_reg   <= rd_addr_next;
            rd_armed_reg  <= rd_armed_next;
            cnt_reg       <= cnt_next;
            tx_data_reg   <= tx_data_next;
            tx_valid_reg  <= tx_valid_next;
            ram_en_reg    <= ram_en_next;
            ram_we_reg    <= ram_we_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            busy_reg      <= busy_next;
            cmd_err_reg   <= cmd_err_next;
        end
    end

    assign tx_data   = tx_data_reg;
    assign tx_valid  = tx_valid_reg;
    assign ram_en    = ram_en_reg;
    assign ram_we    = ram_we_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign busy      = busy_reg;
    assign cmd_err   = cmd_err_reg;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: dut0 (RD_LAT=1, no auto-increment) and
// dut1 (RD_LAT=3, auto-increment), each with a behavioural latency-accurate RAM.
module tb_spi_ram_ctrl;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   fc = 0;

    logic [9:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1;
    logic [7:0] tx_data0, tx_data1;
    logic       tx_valid0, tx_valid1;
    logic       ram_en0, ram_en1, ram_we0, ram_we1;
    logic [7:0] ram_addr0, ram_addr1, ram_wdata0, ram_wdata1, ram_rdata0, ram_rdata1;
    logic       busy0, busy1, cmd_err0, cmd_err1;

    spi_ram_ctrl #(.ADDR_W(8), .RD_LAT(LAT0), .AUTO_INC(0)) dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .ram_en(ram_en0), .ram_we(ram_we0),
        .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0),
        .busy(busy0), .cmd_err(cmd_err0)
    );

    spi_ram_ctrl #(.ADDR_W(8), .RD_LAT(LAT1), .AUTO_INC(1)) dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .ram_en(ram_en1), .ram_we(ram_we1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1),
        .busy(busy1), .cmd_err(cmd_err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: read data emerges exactly LATn cycles after the read cycle.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] pipe0 [4];
    logic [7:0] pipe1 [4];

    always @(posedge clk) begin
        if (ram_en0 && ram_we0) mem0[ram_addr0] <= ram_wdata0;
        pipe0[0] <= (ram_en0 && !ram_we0) ? mem0[ram_addr0] : 8'hEE;
        for (int i = 1; i < 4; i++) pipe0[i] <= pipe0[i-1];
    end

    always @(posedge clk) begin
        if (ram_en1 && ram_we1) mem1[ram_addr1] <= ram_wdata1;
        pipe1[0] <= (ram_en1 && !ram_we1) ? mem1[ram_addr1] : 8'hEE;
        for (int i = 1; i < 4; i++) pipe1[i] <= pipe1[i-1];
    end

    assign ram_rdata0 = pipe0[LAT0-1];
    assign ram_rdata1 = pipe1[LAT1-1];

    typedef struct {
        int cyc;
        int we;
        int a;
        int d;
    } ev_t;

    // Queue index: dut*3 + {0: RAM strobe, 1: tx_valid, 2: cmd_err}
    ev_t ram_q0[$], tx_q0[$], err_q0[$], ram_q1[$], tx_q1[$], err_q1[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void put(input int q, input int c, input int we, input int a, input int d);
        ev_t e;
        e = '{c, we, a, d};
        case (q)
            0: ram_q0.push_back(e);
            1: tx_q0.push_back(e);
            2: err_q0.push_back(e);
            3: ram_q1.push_back(e);
            4: tx_q1.push_back(e);
            5: err_q1.push_back(e);
            default: ;
        endcase
    endfunction

    function automatic bit take(input int q, output ev_t e);
        e = '{0, 0, 0, 0};
        case (q)
            0: if (ram_q0.size() != 0) begin e = ram_q0.pop_front(); return 1'b1; end
            1: if (tx_q0.size()  != 0) begin e = tx_q0.pop_front();  return 1'b1; end
            2: if (err_q0.size() != 0) begin e = err_q0.pop_front(); return 1'b1; end
            3: if (ram_q1.size() != 0) begin e = ram_q1.pop_front(); return 1'b1; end
            4: if (tx_q1.size()  != 0) begin e = tx_q1.pop_front();  return 1'b1; end
            5: if (err_q1.size() != 0) begin e = err_q1.pop_front(); return 1'b1; end
            default: ;
        endcase
        return 1'b0;
    endfunction

    task automatic mon(input int d, input logic en, input logic we, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic bsy, input logic txv,
                       input logic [7:0] txd, input logic err);
        ev_t e;
        if (en) begin
            if (!take(d*3, e)) chk($sformatf("dut%0d_ram_spurious", d), {31'd0, en}, 0);
            else begin
                $display("dut%0d cyc %0d RAM we=%0d addr=%02h wdata=%02h", d, cyc, we, addr, wdata);
                chk($sformatf("dut%0d_ram_cyc", d), cyc, e.cyc);
                chk($sformatf("dut%0d_ram_we", d), {31'd0, we}, e.we);
                chk($sformatf("dut%0d_ram_addr", d), {24'd0, addr}, e.a);
                chk($sformatf("dut%0d_ram_wdata", d), {24'd0, wdata}, e.d);
                chk($sformatf("dut%0d_ram_busy", d), {31'd0, bsy}, 1);
            end
        end
        if (txv) begin
            if (!take(d*3+1, e)) chk($sformatf("dut%0d_tx_spurious", d), {31'd0, txv}, 0);
            else begin
                $display("dut%0d cyc %0d TX data=%02h", d, cyc, txd);
                chk($sformatf("dut%0d_tx_cyc", d), cyc, e.cyc);
                chk($sformatf("dut%0d_tx_data", d), {24'd0, txd}, e.d);
            end
        end
        if (err) begin
            if (!take(d*3+2, e)) chk($sformatf("dut%0d_err_spurious", d), {31'd0, err}, 0);
            else begin
                $display("dut%0d cyc %0d CMD_ERR", d, cyc);
                chk($sformatf("dut%0d_err_cyc", d), cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, ram_en0, ram_we0, ram_addr0, ram_wdata0, busy0, tx_valid0, tx_data0, cmd_err0);
            mon(1, ram_en1, ram_we1, ram_addr1, ram_wdata1, busy1, tx_valid1, tx_data1, cmd_err1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rx_valid0 = 1'b0;
        rx_valid1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic frame(input int d, input logic [9:0] f);
        step();
        if (d == 0) begin rx_data0 = f; rx_valid0 = 1'b1; end
        else        begin rx_data1 = f; rx_valid1 = 1'b1; end
        fc = cyc;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dut0"}, {3'd0, tx_data0, tx_valid0, ram_en0, ram_we0, ram_addr0, ram_wdata0, busy0, cmd_err0}, 0);
        chk({tag, "_dut1"}, {3'd0, tx_data1, tx_valid1, ram_en1, ram_we1, ram_addr1, ram_wdata1, busy1, cmd_err1}, 0);
        $display("%s outputs checked at cyc %0d", tag, cyc);
    endtask

    initial begin
        rx_data0 = '0; rx_valid0 = 1'b0;
        rx_data1 = '0; rx_valid1 = 1'b0;
        #1 rst = 1'b1;
        idle(2);
        chk_zero("reset");
        rst = 1'b0;

        // dut0: RD_DATA straight out of reset is rejected
        frame(0, 10'h300); put(2, fc+1, 0, 0, 0);
        idle(2);
        // dut0: write 0xA7 to 0x05, then read it back
        frame(0, 10'h005);
        frame(0, 10'h1A7); put(0, fc+1, 1, 8'h05, 8'hA7);
        idle(1);
        frame(0, 10'h205);
        frame(0, 10'h300); put(0, fc+1, 0, 8'h05, 0); put(1, fc+3, 0, 0, 8'hA7);
        idle(3);
        // dut0: second RD_DATA without re-arming is rejected
        frame(0, 10'h300); put(2, fc+1, 0, 0, 0);
        idle(1);
        // dut0: address registers are independent
        frame(0, 10'h033);
        frame(0, 10'h1C4); put(0, fc+1, 1, 8'h33, 8'hC4);
        idle(1);
        frame(0, 10'h233);
        frame(0, 10'h010);
        frame(0, 10'h300); put(0, fc+1, 0, 8'h33, 0); put(1, fc+3, 0, 0, 8'hC4);
        idle(3);
        // dut0: frame arriving during WRITE is dropped
        frame(0, 10'h166); put(0, fc+1, 1, 8'h10, 8'h66);
        frame(0, 10'h177); put(2, fc+1, 0, 0, 0);
        frame(0, 10'h210);
        frame(0, 10'h300); put(0, fc+1, 0, 8'h10, 0); put(1, fc+3, 0, 0, 8'h66);
        idle(3);

        // dut1: WR_DATA before any WR_ADDR targets address 0
        frame(1, 10'h1AB); put(3, fc+1, 1, 8'h00, 8'hAB);
        idle(1);
        // dut1: auto-increment wraps 0xFF -> 0x00
        frame(1, 10'h0FF);
        frame(1, 10'h111); put(3, fc+1, 1, 8'hFF, 8'h11);
        idle(1);
        frame(1, 10'h122); put(3, fc+1, 1, 8'h00, 8'h22);
        idle(1);
        // dut1: read 0xFF with RD_LAT=3, frame dropped during RD_WAIT
        frame(1, 10'h2FF);
        frame(1, 10'h300); put(3, fc+1, 0, 8'hFF, 0); put(4, fc+5, 0, 0, 8'h11);
        idle(2);
        frame(1, 10'h3AA); put(5, fc+1, 0, 0, 0);
        idle(2);
        // dut1: read address wrapped to 0x00 and stays armed
        frame(1, 10'h300); put(3, fc+1, 0, 8'h00, 0); put(4, fc+5, 0, 0, 8'h22);
        idle(5);
        // dut1: reset during RD_WAIT aborts the read
        frame(1, 10'h300); put(3, fc+1, 0, 8'h01, 0);
        idle(2);
        step();
        #2 rst = 1'b1;
        #1;
        chk_zero("midrst");
        idle(2);
        rst = 1'b0;
        frame(1, 10'h300); put(5, fc+1, 0, 0, 0);
        frame(0, 10'h300); put(2, fc+1, 0, 0, 0);
        idle(10);

        chk("queues_drained", ram_q0.size() + tx_q0.size() + err_q0.size()
                            + ram_q1.size() + tx_q1.size() + err_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
